// File: rtl/adc_scan_pkg.sv
// Shared constants, FSM state encoding and command builder for the ADC scan controller.
package adc_scan_pkg;

  localparam int unsigned CMD_BITS  = 16;
  localparam int unsigned DATA_BITS = 12;
  localparam int unsigned CH_BITS   = 3;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StCsSetup = 3'd1;
  localparam state_t StShift   = 3'd2;
  localparam state_t StCsHold  = 3'd3;
  localparam state_t StGap     = 3'd4;

  // Start bit, single-ended select, channel, then zero padding; sent MSB first.
  function automatic logic [CMD_BITS-1:0] build_command(input logic [CH_BITS-1:0] ch);
    return {2'b11, ch, 11'b0};
  endfunction

endpackage

// File: rtl/adc_spi_bit_timer.sv
// SCLK half-period timer: counts CLK_DIV system clocks per half and tracks which half
// (low first) is in progress. Restarts from the start of a low half when cleared.
module adc_spi_bit_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic half_tick,
  output logic sample_tick,
  output logic phase_high
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            phase_q;

  assign half_tick   = (cnt_q == CntW'(CLK_DIV - 1));
  assign sample_tick = half_tick & phase_q;
  assign phase_high  = phase_q;

  // Half-period counter and low/high phase flag.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (half_tick) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan_controller.sv
// SPI master that scans ADC channels round-robin, one 16-bit transaction per channel,
// and strobes each 12-bit result out with its channel number.
module adc_scan_controller
  import adc_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned GAP_CYCLES   = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 adc_miso,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic                 adc_mosi,
  output logic [DATA_BITS-1:0] sample_data,
  output logic [CH_BITS-1:0]   sample_channel,
  output logic                 sample_valid,
  output logic                 busy
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t               state_q, state_d;
  logic [3:0]           bit_q;
  logic [GapW-1:0]      gap_q;
  logic [CH_BITS-1:0]   ch_q;
  logic [CMD_BITS-1:0]  cmd_q, cmd_d;
  logic [CMD_BITS-1:0]  rx_q;
  logic                 half_tick, sample_tick, phase_high;
  logic                 sclk_d, finish_xfer;
  logic                 unused_rx_msb;

  // The top response bit falls off the shift register and is never needed.
  assign unused_rx_msb = rx_q[CMD_BITS-1];

  adc_spi_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (state_d != state_q),
    .half_tick  (half_tick),
    .sample_tick(sample_tick),
    .phase_high (phase_high)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (enable) state_d = StCsSetup;
      StCsSetup: if (half_tick) state_d = StShift;
      StShift:   if (sample_tick && bit_q == 4'd15) state_d = StCsHold;
      StCsHold:  if (half_tick) state_d = StGap;
      StGap:     if (gap_q == GapW'(GAP_CYCLES - 1)) state_d = enable ? StCsSetup : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign finish_xfer = (state_q == StCsHold) && (state_d == StGap);

  // SCLK goes high for the second half of each bit period while shifting.
  assign sclk_d = (state_q == StShift) && (state_d == StShift) && (phase_high ^ half_tick);

  // Command shift register: loaded on entry to setup, advanced after each sampled bit.
  always_comb begin
    cmd_d = cmd_q;
    if (state_d == StCsSetup && state_q != StCsSetup) begin
      cmd_d = build_command(ch_q);
    end else if (state_q == StShift && sample_tick) begin
      cmd_d = {cmd_q[CMD_BITS-2:0], 1'b0};
    end
  end

  // FSM, counters and shift registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      bit_q   <= '0;
      gap_q   <= '0;
      ch_q    <= '0;
      cmd_q   <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      if (state_q != StShift) bit_q <= '0;
      else if (sample_tick)   bit_q <= bit_q + 4'd1;
      if (state_q != StGap) gap_q <= '0;
      else                  gap_q <= gap_q + 1'b1;
      if (state_q == StShift && sample_tick) rx_q <= {rx_q[CMD_BITS-2:0], adc_miso};
      // Leaving the scan always restarts at channel 0.
      if (state_d == StIdle) begin
        ch_q <= '0;
      end else if (finish_xfer) begin
        ch_q <= (ch_q == CH_BITS'(NUM_CHANNELS - 1)) ? '0 : ch_q + 1'b1;
      end
    end
  end

  // Registered outputs, computed from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      adc_cs_n       <= 1'b1;
      adc_sclk       <= 1'b0;
      adc_mosi       <= 1'b0;
      sample_data    <= '0;
      sample_channel <= '0;
      sample_valid   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      adc_cs_n     <= !(state_d inside {StCsSetup, StShift, StCsHold});
      adc_sclk     <= sclk_d;
      adc_mosi     <= (state_d inside {StCsSetup, StShift}) ? cmd_d[CMD_BITS-1] : 1'b0;
      busy         <= (state_d != StIdle);
      sample_valid <= finish_xfer;
      if (finish_xfer) begin
        sample_data    <= rx_q[DATA_BITS-1:0];
        sample_channel <= ch_q;
      end
    end
  end

endmodule
